operand_loader_8_bit: RTL and testbench
=======================================

OPERAND_LOADER_8_BIT -- requirements
Module: operand_loader_8_bit

Interface
REQ-001 Parameter: WIDTH, 8, operand and byte-stream data width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: in_data  input  WIDTH  serial operand byte stream, A first then B.
REQ-005 Port: in_valid  input  1  in_data holds a valid byte.
REQ-006 Port: in_ready  output  1  loader accepts a byte this cycle.
REQ-007 Port: a  output  WIDTH  operand A presented to the downstream 8-bit logic unit (xor_8_bit and peers).
REQ-008 Port: b  output  WIDTH  operand B presented to the downstream unit.
REQ-009 Port: out_valid  output  1  a/b hold a complete operand pair.
REQ-010 Port: out_ready  input  1  downstream consumer accepts the pair.
REQ-011 The block SHALL use one clock (clk); reset rst_n SHALL be asynchronous and active-low.

Function
REQ-012 The block SHALL implement an FSM with states LOAD_A, LOAD_B and HOLD, encoded in registers.
REQ-013 An input transfer SHALL occur on a rising clk edge where in_valid=1 and in_ready=1.
REQ-014 in_ready SHALL be 1 in LOAD_A and LOAD_B and 0 in HOLD, decoded combinationally from state only.
REQ-015 In LOAD_A, an input transfer SHALL register in_data into a and move to LOAD_B.
REQ-016 In LOAD_B, an input transfer SHALL register in_data into b and move to HOLD.
REQ-017 In LOAD_A or LOAD_B with in_valid=0, state, a and b SHALL hold.
REQ-018 out_valid SHALL be 1 exactly while in HOLD and registered (no combinational path from any input).
REQ-019 Latency: out_valid SHALL rise on the edge that accepts the B byte, i.e. visible the cycle after B is presented.
REQ-020 In HOLD, an output transfer (out_valid=1 and out_ready=1 at an edge) SHALL move to LOAD_A.
REQ-021 In HOLD with out_ready=0, a, b and out_valid SHALL stay stable indefinitely.
REQ-022 a and b SHALL retain the previous pair after an output transfer until overwritten by the next A/B byte.
REQ-023 out_ready asserted outside HOLD SHALL be ignored; in_valid asserted in HOLD SHALL be ignored (no byte lost: producer holds it).
REQ-024 A new A byte SHALL NOT be accepted in the same cycle as the output transfer; the earliest next A transfer is the edge after leaving HOLD.
REQ-025 Sustained throughput SHALL be one pair per 3 cycles with in_valid and out_ready held at 1.

Reset
REQ-026 While rst_n=0: state=LOAD_A, a=0, b=0, out_valid=0, in_ready=1 (decoded), optional pair_cnt=0.
REQ-027 Reset asserted mid-operation (LOAD_B or HOLD) SHALL immediately discard the partial or pending pair without waiting for clk.
REQ-028 After rst_n deasserts, the first in_valid=1 edge SHALL load a.

Configuration
REQ-029 Macro OPERAND_LOADER_CNT_EN, when defined, SHALL add output port pair_cnt (WIDTH bits) counting completed output transfers.
REQ-030 With OPERAND_LOADER_CNT_EN, pair_cnt SHALL increment by 1 on each output transfer and wrap 255 -> 0 without a flag.
REQ-031 Without OPERAND_LOADER_CNT_EN, the pair_cnt port and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset, then bytes 0x01, 0x16 with in_valid=1, out_ready=0 -> a=0x01, b=0x16, out_valid=1 held stable for 10 cycles, in_ready=0.
REQ-033 Bytes 0x07, 0x0A, out_ready=1 -> out_valid high exactly 1 cycle, then LOAD_A with a=0x07, b=0x0A retained.
REQ-034 in_valid toggling 1,0,0,1 with bytes 0xFF, 0x00 -> out_valid rises 1 cycle after the second accepted byte, pair=(0xFF,0x00).
REQ-035 Drop rst_n mid-LOAD_B after a=0x55 -> a=0, out_valid=0, in_ready=1 asynchronously; next byte 0x33 lands in a.
REQ-036 With OPERAND_LOADER_CNT_EN, 256 back-to-back pairs with out_ready=1 -> pair_cnt wraps to 0, each pair 3 cycles apart.

Source files
------------

// File: rtl/operand_loader_8_bit.sv
`timescale 1ns/1ps
// operand_loader_8_bit
//
// Builds an operand pair for a downstream 8-bit logic unit (xor_8_bit and
// similar) from a serial byte stream. The first byte accepted is operand A and
// the second is operand B. The pair is then presented with out_valid until the
// consumer takes it.
//
// Ports
//   clk        single clock, rising-edge
//   rst_n      asynchronous, active-low reset
//   in_data    byte stream, A then B
//   in_valid   in_data holds a valid byte
//   in_ready   loader accepts a byte this cycle (decoded from state only)
//   a, b       registered operand pair
//   out_valid  a/b hold a complete pair (registered)
//   out_ready  consumer accepts the pair
//   pair_cnt   completed output transfers, wraps silently
//              (present only with OPERAND_LOADER_CNT_EN defined)
//
// Build option
//   OPERAND_LOADER_CNT_EN : adds the pair_cnt port and its counter.
//
// state  | meaning
// -------+-----------------------------------------------------------
// LOAD_A | waiting for operand A byte, in_ready=1
// LOAD_B | A captured, waiting for operand B byte, in_ready=1
// HOLD   | pair complete, out_valid=1, waiting for out_ready
module operand_loader_8_bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready
`ifdef OPERAND_LOADER_CNT_EN
  ,
  output logic [WIDTH-1:0] pair_cnt
`endif
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             out_valid_q, out_valid_d;
  logic             in_xfer;

  // Ready depends on the state register alone, so there is no path from
  // in_valid or out_ready to in_ready.
  assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign in_xfer  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;

    case (state_q)
      LOAD_A: begin
        if (in_xfer) begin
          a_d     = in_data;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (in_xfer) begin
          b_d     = in_data;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Leaving HOLD takes a full cycle, so no A byte can be accepted on
        // the same edge as the output transfer. a/b keep the old pair.
        if (out_ready) begin
          state_d = LOAD_A;
        end
      end
      default: begin
        state_d = LOAD_A;
      end
    endcase

    // Registered copy of "next state is HOLD" keeps out_valid glitch-free and
    // rising on the same edge that captures B.
    out_valid_d = (state_d == HOLD);
  end

  assign a         = a_q;
  assign b         = b_q;
  assign out_valid = out_valid_q;

`ifdef OPERAND_LOADER_CNT_EN
  logic [WIDTH-1:0] pair_cnt_q, pair_cnt_d;
  logic             out_xfer;

  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    pair_cnt_d = pair_cnt_q;
    if (out_xfer) begin
      pair_cnt_d = pair_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_cnt_q <= '0;
    end else begin
      pair_cnt_q <= pair_cnt_d;
    end
  end

  assign pair_cnt = pair_cnt_q;
`endif

endmodule

// File: tb/tb_operand_loader_8_bit.sv
`timescale 1ns/1ps
// Testbench for operand_loader_8_bit. Optional counter checks follow
// OPERAND_LOADER_CNT_EN.
module tb_operand_loader_8_bit;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
`ifdef OPERAND_LOADER_CNT_EN
  logic [7:0] pair_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Transaction-level reference: how many bytes of the pending pair have
  // been collected, the captured bytes, and the number of pairs consumed.
  int         m_bytes;
  logic [7:0] m_a;
  logic [7:0] m_b;
  int         m_pairs;

  operand_loader_8_bit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef OPERAND_LOADER_CNT_EN
    ,
    .pair_cnt  (pair_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_bytes = 0;
    m_a     = 8'h00;
    m_b     = 8'h00;
    m_pairs = 0;
  endtask

  // One clock: drive inputs, advance to the edge, update the reference with
  // the values seen at that edge, then settle 1ns past the edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    if (m_bytes == 2) begin
      if (r) begin
        m_bytes = 0;
        m_pairs = m_pairs + 1;
      end
    end else if (v) begin
      if (m_bytes == 0) m_a = d;
      else              m_b = d;
      m_bytes = m_bytes + 1;
    end
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    model_reset();
    #3;
    checks++; if (a !== 8'h00)     begin errors++; $display("FAIL reset_a: got %h expected 00", a); end
    checks++; if (b !== 8'h00)     begin errors++; $display("FAIL reset_b: got %h expected 00", b); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a !== 8'h00) begin errors++; $display("FAIL reset_a_clocked: got %h expected 00", a); end
`ifdef OPERAND_LOADER_CNT_EN
    checks++; if (pair_cnt !== 8'h00) begin errors++; $display("FAIL reset_pair_cnt: got %h expected 00", pair_cnt); end
`endif
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    cycle(1'b1, 8'h3C, 1'b0);
    checks++; if (a !== 8'h3C) begin errors++; $display("FAIL first_byte_to_a: got %h expected 3c", a); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL first_byte_out_valid: got %b expected 0", out_valid); end
    do_reset();
  endtask

  task automatic test_hold_stable();
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'h16, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (a !== 8'h01 || b !== 8'h16 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got a=%h b=%h ov=%b ir=%b expected a=01 b=16 ov=1 ir=0",
                 i, a, b, out_valid, in_ready);
      end
      cycle(1'b1, 8'($urandom), 1'b0);
    end
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got %b expected 0", out_valid); end
  endtask

  task automatic test_out_pulse();
    cycle(1'b1, 8'h07, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pulse_after_a: got %b expected 0", out_valid); end
    cycle(1'b1, 8'h0A, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pulse_high: got %b expected 1", out_valid); end
    cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || a !== 8'h07 || b !== 8'h0A) begin
      errors++;
      $display("FAIL pulse_retain: got ov=%b ir=%b a=%h b=%h expected ov=0 ir=1 a=07 b=0a",
               out_valid, in_ready, a, b);
    end
  endtask

  task automatic test_gaps();
    cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b0, 8'h12, 1'b0);
    cycle(1'b0, 8'h34, 1'b0);
    checks++; if (out_valid !== 1'b0 || a !== 8'hFF) begin errors++; $display("FAIL gap_wait: got ov=%b a=%h expected ov=0 a=ff", out_valid, a); end
    cycle(1'b1, 8'h00, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || a !== 8'hFF || b !== 8'h00) begin
      errors++;
      $display("FAIL gap_pair: got ov=%b a=%h b=%h expected ov=1 a=ff b=00", out_valid, a, b);
    end
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 8'h55, 1'b0);
    checks++; if (a !== 8'h55) begin errors++; $display("FAIL areset_load: got %h expected 55", a); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (a !== 8'h00 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_immediate: got a=%h ov=%b ir=%b expected a=00 ov=0 ir=1", a, out_valid, in_ready);
    end
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 8'h33, 1'b0);
    checks++;
    if (a !== 8'h33 || b !== 8'h00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_next: got a=%h b=%h ir=%b expected a=33 b=00 ir=1", a, b, in_ready);
    end
    // Reset while holding a complete pair.
    cycle(1'b1, 8'h44, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || b !== 8'h00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_hold: got ov=%b b=%h ir=%b expected ov=0 b=00 ir=1", out_valid, b, in_ready);
    end
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      checks++;
      if (a !== m_a || b !== m_b || out_valid !== (m_bytes == 2) || in_ready !== (m_bytes < 2)) begin
        errors++;
        $display("FAIL random[%0d]: got a=%h b=%h ov=%b ir=%b expected a=%h b=%h ov=%b ir=%b",
                 i, a, b, out_valid, in_ready, m_a, m_b, (m_bytes == 2), (m_bytes < 2));
      end
`ifdef OPERAND_LOADER_CNT_EN
      checks++;
      if (pair_cnt !== 8'(m_pairs)) begin
        errors++;
        $display("FAIL random_cnt[%0d]: got %h expected %h", i, pair_cnt, 8'(m_pairs));
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
`ifdef OPERAND_LOADER_CNT_EN
    int n_pairs = 256;
`else
    int n_pairs = 16;
`endif
    int seen = 0;
    int last = -1;
    do_reset();
    for (int i = 0; i < 3 * n_pairs; i++) begin
      cycle(1'b1, 8'($urandom), 1'b1);
      if (out_valid === 1'b1) begin
        checks++;
        if (a !== m_a || b !== m_b) begin
          errors++;
          $display("FAIL b2b_pair[%0d]: got a=%h b=%h expected a=%h b=%h", seen, a, b, m_a, m_b);
        end
        if (last >= 0) begin
          checks++;
          if (i - last != 3) begin
            errors++;
            $display("FAIL b2b_spacing[%0d]: got %0d cycles expected 3", seen, i - last);
          end
        end
        last = i;
        seen++;
      end
    end
    cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (seen != n_pairs) begin
      errors++;
      $display("FAIL b2b_count: got %0d pairs expected %0d", seen, n_pairs);
    end
`ifdef OPERAND_LOADER_CNT_EN
    checks++;
    if (pair_cnt !== 8'(m_pairs) || pair_cnt !== 8'h00) begin
      errors++;
      $display("FAIL b2b_cnt_wrap: got %h expected 00", pair_cnt);
    end
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    model_reset();
    test_reset();
    test_hold_stable();
    test_out_pulse();
    test_gaps();
    test_async_reset();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
